// File: rtl/ram_io_responder.sv
// ram_io_responder: memory-side responder for the memctrl byte bus.
// Provides a byte-wide RAM with a fixed 1-cycle read latency, plus memory-mapped IO:
//   0x30000 write pushes into the TX FIFO, read returns 0
//   0x30004 write sets the sticky end-of-sim flag, read returns the FIFO count
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   rdy                 bus-side enable (the TX drain keeps running while it is low)
//   iMEM_rw/addr/dt     beat from memctrl (rw=1 write)
//   oMEM_dt             registered read byte
//   oIO_buffer_full     registered back-pressure to memctrl
//   oTX_valid/oTX_byte  TX FIFO head; iTX_ready pops it
//   oSIM_end, oOVF      sticky status flags
module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iMEM_rw,
  input  logic [31:0] iMEM_addr,
  input  logic [7:0]  iMEM_dt,
  output logic [7:0]  oMEM_dt,
  output logic        oIO_buffer_full,
  output logic        oTX_valid,
  output logic [7:0]  oTX_byte,
  input  logic        iTX_ready,
  output logic        oSIM_end,
  output logic        oOVF
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] TX_ADDR  = 32'h0003_0000;
  localparam logic [31:0] END_ADDR = 32'h0003_0004;

  logic [7:0]            mem  [2**ADDR_WIDTH];
  logic [7:0]            fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  io, bus_wr, bus_rd, push_req, push, pop, drop;

  // Decode the beat and resolve FIFO push/pop for this edge
  always_comb begin
    idx        = iMEM_addr[ADDR_WIDTH-1:0];
    io         = (iMEM_addr[17:16] == 2'b11);
    bus_wr     = rst && rdy && iMEM_rw;
    bus_rd     = rst && rdy && !iMEM_rw;
    push_req   = bus_wr && (iMEM_addr == TX_ADDR);
    pop        = (count != '0) && iTX_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push       = push_req && ((count != CNT_W'(FIFO_DEPTH)) || pop);
    drop       = push_req && !push;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign oTX_valid = (count != '0);
  assign oTX_byte  = fifo[rd_ptr];

  // RAM and FIFO storage: contents survive reset
  always_ff @(posedge clk) begin
    if (bus_wr && !io) mem[idx] <= iMEM_dt;
    if (push)          fifo[wr_ptr] <= iMEM_dt;
  end

  // Read data path
  always_ff @(posedge clk) begin
    if (!rst) begin
      oMEM_dt <= 8'h00;
    end else if (bus_rd) begin
      if (!io)                          oMEM_dt <= mem[idx];
      else if (iMEM_addr == END_ADDR)   oMEM_dt <= 8'(count);
      else                              oMEM_dt <= 8'h00;
    end
  end

  // FIFO pointers, status flags and back-pressure
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      oIO_buffer_full <= 1'b0;
      oSIM_end        <= 1'b0;
      oOVF            <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      count           <= count_next;
      oIO_buffer_full <= ((CNT_W'(FIFO_DEPTH) - count_next) <= CNT_W'(FULL_MARGIN));
      if (drop) oOVF <= 1'b1;
      if (bus_wr && (iMEM_addr == END_ADDR)) oSIM_end <= 1'b1;
    end
  end

endmodule
